// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use interlock.
//
// Captures the decoded instruction and its register operands into the EX
// slot. Every edge applies one action: flush (kill the EX slot), HOLD (EX is
// stalled, keep contents), BUBBLE (insert a nop behind a load whose result
// the ID instruction needs) or RUN (capture the ID instruction).
// Priority is flush > exStall > load-use > capture.
//
// Handshake: idValid qualifies the ID-side fields. idStall is this stage's
// "not ready" towards ID/IF. An ID instruction moves into EX on an edge where
// idValid=1, idStall=0 and flush=0. exStall is EX's "not ready" towards us;
// while it is high the EX slot holds its contents.
//
// Optional feature macro: ID_EX_WB_BYPASS_EN
//   defined   -> captured operands take the writeback value on a register
//                match, and held operands are refreshed from writeback.
//   undefined -> operands come only from readData1/readData2; wb* ignored.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   idValid..idRegWrite        decoded ID instruction
//   readData1/readData2        register-file values of idRs/idRt
//   wbRegWrite/wbWriteReg/wbWriteData  writeback port
//   flush, exStall             pipeline control
//   exValid..exData2           registered EX slot
//   idStall                    hold PC and IF/ID (combinational)
//   bubbleCount                saturating count of inserted bubbles
//   dbgState                   action applied at the most recent edge
// ----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idValid,
    input  logic [31:0] idPc,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic [4:0]  idDest,
    input  logic [31:0] idImm,
    input  logic [15:0] idCtrl,
    input  logic        idMemRead,
    input  logic        idRegWrite,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbWriteReg,
    input  logic [31:0] wbWriteData,
    input  logic        flush,
    input  logic        exStall,
    output logic        exValid,
    output logic [31:0] exPc,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exDest,
    output logic [31:0] exImm,
    output logic [15:0] exCtrl,
    output logic        exMemRead,
    output logic        exRegWrite,
    output logic [31:0] exData1,
    output logic [31:0] exData2,
    output logic        idStall,
    output logic [15:0] bubbleCount,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } stageState_t;

    stageState_t state, nextState;
    logic        loadUse;
    logic [31:0] capData1, capData2;
    logic [31:0] holdData1, holdData2;

    // The load in EX produces its value too late for the ID instruction.
    assign loadUse = exValid & exMemRead & (exDest != 5'd0) & idValid &
                     ((exDest == idRs) | (exDest == idRt));

`ifdef ID_EX_WB_BYPASS_EN
    logic wbHitId1, wbHitId2, wbHitEx1, wbHitEx2;

    assign wbHitId1 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == idRs);
    assign wbHitId2 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == idRt);
    assign wbHitEx1 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == exRs);
    assign wbHitEx2 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == exRt);

    assign capData1  = (idRs == 5'd0) ? 32'h0 : (wbHitId1 ? wbWriteData : readData1);
    assign capData2  = (idRt == 5'd0) ? 32'h0 : (wbHitId2 ? wbWriteData : readData2);
    // A stalled EX instruction must not miss a write that lands while it waits.
    assign holdData1 = wbHitEx1 ? wbWriteData : exData1;
    assign holdData2 = wbHitEx2 ? wbWriteData : exData2;
`else
    logic unusedWb;

    assign unusedWb  = ^{wbRegWrite, wbWriteReg, wbWriteData};
    assign capData1  = (idRs == 5'd0) ? 32'h0 : readData1;
    assign capData2  = (idRt == 5'd0) ? 32'h0 : readData2;
    assign holdData1 = exData1;
    assign holdData2 = exData2;
`endif

    // Next action and stall request; flush always wins and never stalls ID.
    always_comb begin
        nextState = RUN;
        idStall   = 1'b0;
        if (flush) begin
            nextState = RUN;
            idStall   = 1'b0;
        end else if (exStall) begin
            nextState = HOLD;
            idStall   = 1'b1;
        end else if (loadUse) begin
            nextState = BUBBLE;
            idStall   = 1'b1;
        end
    end

    assign dbgState = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            exValid     <= 1'b0;
            exPc        <= 32'h0;
            exRs        <= 5'd0;
            exRt        <= 5'd0;
            exDest      <= 5'd0;
            exImm       <= 32'h0;
            exCtrl      <= 16'h0;
            exMemRead   <= 1'b0;
            exRegWrite  <= 1'b0;
            exData1     <= 32'h0;
            exData2     <= 32'h0;
            bubbleCount <= 16'h0;
        end else begin
            state <= nextState;
            case (nextState)
                HOLD: begin
                    exData1 <= holdData1;
                    exData2 <= holdData2;
                end
                BUBBLE: begin
                    exValid    <= 1'b0;
                    exMemRead  <= 1'b0;
                    exRegWrite <= 1'b0;
                    if (bubbleCount != 16'hFFFF) begin
                        bubbleCount <= bubbleCount + 16'd1;
                    end
                end
                default: begin
                    if (flush) begin
                        exValid    <= 1'b0;
                        exMemRead  <= 1'b0;
                        exRegWrite <= 1'b0;
                    end else begin
                        exValid    <= idValid;
                        exPc       <= idPc;
                        exRs       <= idRs;
                        exRt       <= idRt;
                        exDest     <= idDest;
                        exImm      <= idImm;
                        exCtrl     <= idCtrl;
                        exMemRead  <= idMemRead;
                        exRegWrite <= idRegWrite;
                        exData1    <= capData1;
                        exData2    <= capData2;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage -- directed bench for id_ex_stage.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, well away from the next edge. Expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        idValid;
    logic [31:0] idPc;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic [4:0]  idDest;
    logic [31:0] idImm;
    logic [15:0] idCtrl;
    logic        idMemRead;
    logic        idRegWrite;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        flush;
    logic        exStall;
    logic        exValid;
    logic [31:0] exPc;
    logic [4:0]  exRs;
    logic [4:0]  exRt;
    logic [4:0]  exDest;
    logic [31:0] exImm;
    logic [15:0] exCtrl;
    logic        exMemRead;
    logic        exRegWrite;
    logic [31:0] exData1;
    logic [31:0] exData2;
    logic        idStall;
    logic [15:0] bubbleCount;
    logic [1:0]  dbgState;

    int errors;
    int checks;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

`ifdef ID_EX_WB_BYPASS_EN
    localparam logic [31:0] EXP_BYPASS = 32'hCAFE0001;
    localparam logic [31:0] EXP_REFRESH = 32'h12345678;
`else
    localparam logic [31:0] EXP_BYPASS = 32'h0;
    localparam logic [31:0] EXP_REFRESH = 32'hAAAA0000;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .idValid(idValid), .idPc(idPc), .idRs(idRs), .idRt(idRt),
        .idDest(idDest), .idImm(idImm), .idCtrl(idCtrl),
        .idMemRead(idMemRead), .idRegWrite(idRegWrite),
        .readData1(readData1), .readData2(readData2),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
        .flush(flush), .exStall(exStall),
        .exValid(exValid), .exPc(exPc), .exRs(exRs), .exRt(exRt),
        .exDest(exDest), .exImm(exImm), .exCtrl(exCtrl),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite),
        .exData1(exData1), .exData2(exData2),
        .idStall(idStall), .bubbleCount(bubbleCount), .dbgState(dbgState)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setId(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dest,
                         input logic [31:0] imm, input logic [15:0] ctrl,
                         input logic mr, input logic rw,
                         input logic [31:0] rd1, input logic [31:0] rd2);
        idValid = v; idPc = pc; idRs = rs; idRt = rt; idDest = dest;
        idImm = imm; idCtrl = ctrl; idMemRead = mr; idRegWrite = rw;
        readData1 = rd1; readData2 = rd2;
    endtask

    task automatic setWb(input logic we, input logic [4:0] reg_i, input logic [31:0] data);
        wbRegWrite = we; wbWriteReg = reg_i; wbWriteData = data;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        exStall = 1'b0;
        setId(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);
        #1;

        // reset state, before any clock edge
        chk("rst_exValid", exValid, 0);
        chk("rst_exPc", exPc, 0);
        chk("rst_exData1", exData1, 0);
        chk("rst_bubbleCount", bubbleCount, 0);
        chk("rst_idStall", idStall, 0);
        chk("rst_state", dbgState, ST_RUN);
        tick();
        rst_n = 1'b1;

        // plain capture
        setId(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h10, 16'hA5A5, 1'b0, 1'b1,
              32'h11111111, 32'h22222222);
        tick();
        chk("cap_exValid", exValid, 1);
        chk("cap_exPc", exPc, 32'h100);
        chk("cap_exDest", exDest, 3);
        chk("cap_exImm", exImm, 32'h10);
        chk("cap_exCtrl", exCtrl, 16'hA5A5);
        chk("cap_exRegWrite", exRegWrite, 1);
        chk("cap_exData1", exData1, 32'h11111111);
        chk("cap_exData2", exData2, 32'h22222222);
        chk("cap_idStall", idStall, 0);

        // writeback bypass into the captured operand
        setId(1'b1, 32'h104, 5'd5, 5'd6, 5'd7, 32'h0, 16'h0, 1'b0, 1'b1,
              32'h0, 32'h66666666);
        setWb(1'b1, 5'd5, 32'hCAFE0001);
        tick();
        chk("byp_exData1", exData1, EXP_BYPASS);
        chk("byp_exData2", exData2, 32'h66666666);

        // register 0 reads as zero even with a writeback to reg 0
        setId(1'b1, 32'h108, 5'd0, 5'd0, 5'd7, 32'h0, 16'h0, 1'b0, 1'b1,
              32'hFFFFFFFF, 32'hFFFFFFFF);
        setWb(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        chk("r0_exData1", exData1, 0);
        chk("r0_exData2", exData2, 0);
        setWb(1'b0, 5'd0, 32'h0);

        // load-use: lw r8 then a consumer of r8 through rt
        setId(1'b1, 32'h200, 5'd1, 5'd4, 5'd8, 32'h0, 16'h0, 1'b1, 1'b1,
              32'h1, 32'h4);
        tick();
        chk("lw_exMemRead", exMemRead, 1);
        setId(1'b1, 32'h204, 5'd3, 5'd8, 5'd9, 32'h0, 16'h0, 1'b0, 1'b1,
              32'h33, 32'h88);
        #1;
        chk("lu_idStall_same", idStall, 1);
        tick();
        chk("lu_exValid", exValid, 0);
        chk("lu_exMemRead", exMemRead, 0);
        chk("lu_exRegWrite", exRegWrite, 0);
        chk("lu_bubbleCount", bubbleCount, 1);
        chk("lu_state", dbgState, ST_BUBBLE);
        chk("lu_idStall_after", idStall, 0);
        tick();
        chk("lu_cap_exValid", exValid, 1);
        chk("lu_cap_exPc", exPc, 32'h204);
        chk("lu_cap_exData2", exData2, 32'h88);
        chk("lu_cap_bubbleCount", bubbleCount, 1);
        chk("lu_cap_state", dbgState, ST_RUN);

        // load to r0 never interlocks
        setId(1'b1, 32'h208, 5'd1, 5'd2, 5'd0, 32'h0, 16'h0, 1'b1, 1'b0,
              32'h1, 32'h2);
        tick();
        setId(1'b1, 32'h20C, 5'd0, 5'd0, 5'd3, 32'h0, 16'h0, 1'b0, 1'b1,
              32'h0, 32'h0);
        #1;
        chk("ld_r0_idStall", idStall, 0);

        // load-use through rs
        tick();
        setId(1'b1, 32'h210, 5'd1, 5'd2, 5'd12, 32'h0, 16'h0, 1'b1, 1'b1,
              32'h1, 32'h2);
        tick();
        setId(1'b1, 32'h214, 5'd12, 5'd2, 5'd13, 32'h0, 16'h0, 1'b0, 1'b1,
              32'h0, 32'h0);
        #1;
        chk("lu_rs_idStall", idStall, 1);
        tick();
        chk("lu_rs_bubbleCount", bubbleCount, 2);
        tick();
        chk("lu_rs_cap_exPc", exPc, 32'h214);

        // EX stall for 3 cycles with a writeback to the held rs in cycle 2
        setId(1'b1, 32'h300, 5'd9, 5'd10, 5'd11, 32'h77, 16'h1234, 1'b0, 1'b1,
              32'hAAAA0000, 32'hBBBB0000);
        tick();
        chk("hold_pre_exData1", exData1, 32'hAAAA0000);
        exStall = 1'b1;
        setId(1'b1, 32'h400, 5'd14, 5'd15, 5'd16, 32'h99, 16'h4321, 1'b0, 1'b1,
              32'h14, 32'h15);
        #1;
        chk("hold_idStall", idStall, 1);
        tick();
        chk("hold_state", dbgState, ST_HOLD);
        chk("hold1_exPc", exPc, 32'h300);
        setWb(1'b1, 5'd9, 32'h12345678);
        tick();
        setWb(1'b0, 5'd0, 32'h0);
        tick();
        chk("hold_exData1", exData1, EXP_REFRESH);
        chk("hold_exData2", exData2, 32'hBBBB0000);
        chk("hold_exPc", exPc, 32'h300);
        chk("hold_exImm", exImm, 32'h77);
        chk("hold_exCtrl", exCtrl, 16'h1234);
        chk("hold_exValid", exValid, 1);
        chk("hold_bubbleCount", bubbleCount, 2);
        exStall = 1'b0;
        tick();
        chk("release_exPc", exPc, 32'h400);
        chk("release_exData1", exData1, 32'h14);

        // flush beats exStall and load-use
        setId(1'b1, 32'h500, 5'd1, 5'd2, 5'd8, 32'h0, 16'h0, 1'b1, 1'b1,
              32'h1, 32'h2);
        tick();
        setId(1'b1, 32'h504, 5'd3, 5'd8, 5'd9, 32'h0, 16'h0, 1'b0, 1'b1,
              32'h3, 32'h8);
        exStall = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl_idStall", idStall, 0);
        tick();
        chk("fl_exValid", exValid, 0);
        chk("fl_exMemRead", exMemRead, 0);
        chk("fl_exRegWrite", exRegWrite, 0);
        chk("fl_bubbleCount", bubbleCount, 2);
        chk("fl_state", dbgState, ST_RUN);
        flush = 1'b0;
        exStall = 1'b0;
        tick();
        chk("fl_next_exValid", exValid, 1);
        chk("fl_next_exPc", exPc, 32'h504);

        // asynchronous reset mid-cycle, no clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_exValid", exValid, 0);
        chk("arst_exPc", exPc, 0);
        chk("arst_exData1", exData1, 0);
        chk("arst_exData2", exData2, 0);
        chk("arst_exDest", exDest, 0);
        chk("arst_exRegWrite", exRegWrite, 0);
        chk("arst_bubbleCount", bubbleCount, 0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_resume_exValid", exValid, 1);
        chk("arst_resume_exPc", exPc, 32'h504);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
